dcache_refill_ctrl: RTL and testbench

Miss-handling controller for the data cache. On a lookup miss it latches the victim way chosen by the replacement selector. If the victim line is valid and dirty, it writes that line back to memory as a burst. It then fetches the missed line as a burst and writes it, with its tag, into the chosen way. It sits between the dcache lookup/replacement logic and the memory bus interface.

---
 rtl/dcache_refill_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl
// Miss-handling controller for the data cache. On a lookup miss it captures
// the missed address and the victim way chosen by the replacement selector.
// If the victim line is valid and dirty, it writes the line back as a burst.
// It then fetches the missed line as a burst and writes it, with its tag,
// into the captured way.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   miss_req, miss_addr            miss request (held until miss_done) and address
//   victim_way/valid/dirty/tag     replacement-selector view of the victim line
//   rd_word, rd_data               word select and combinational data-array read
//   mem_wr_req/addr/gnt            write-burst address channel
//   mem_wr_valid/data/last/ready   write-burst beat channel
//   mem_wr_done                    write response
//   mem_rd_req/addr/gnt            read-burst address channel
//   mem_rd_valid/data/last         read-burst beat channel (always accepted)
//   line_we/way/index/word/wdata   data-array word write
//   tag_we, tag_wdata              tag write (line becomes valid and clean)
//   busy, miss_done                controller active / one-cycle completion
module dcache_refill_ctrl #(
  parameter int LINE_NUM = 4,
  parameter int WORDS    = 8,
  parameter int INDEX_W  = 7,
  localparam int WAY_W   = $clog2(LINE_NUM),
  localparam int WORD_W  = $clog2(WORDS),
  localparam int OFF_W   = $clog2(WORDS) + 2,
  localparam int TAG_W   = 32 - INDEX_W - OFF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  input  logic [WAY_W-1:0]   victim_way,
  input  logic               victim_valid,
  input  logic               victim_dirty,
  input  logic [TAG_W-1:0]   victim_tag,
  output logic [WORD_W-1:0]  rd_word,
  input  logic [31:0]        rd_data,
  output logic               mem_wr_req,
  output logic [31:0]        mem_wr_addr,
  input  logic               mem_wr_gnt,
  output logic               mem_wr_valid,
  output logic [31:0]        mem_wr_data,
  output logic               mem_wr_last,
  input  logic               mem_wr_ready,
  input  logic               mem_wr_done,
  output logic               mem_rd_req,
  output logic [31:0]        mem_rd_addr,
  input  logic               mem_rd_gnt,
  input  logic               mem_rd_valid,
  input  logic [31:0]        mem_rd_data,
  input  logic               mem_rd_last,
  output logic               line_we,
  output logic [WAY_W-1:0]   line_way,
  output logic [INDEX_W-1:0] line_index,
  output logic [WORD_W-1:0]  line_word,
  output logic [31:0]        line_wdata,
  output logic               tag_we,
  output logic [TAG_W-1:0]   tag_wdata,
  output logic               busy,
  output logic               miss_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_DATA = 3'd2,
    WB_RESP = 3'd3,
    RD_REQ  = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

  state_t                   state_r, state_nxt;
  logic [WORD_W-1:0]        cnt_r, cnt_nxt, cnt_inc;
  // Line address of the miss: {tag, index}; the byte offset is never needed.
  logic [INDEX_W+TAG_W-1:0] line_addr_r;
  logic [WAY_W-1:0]         way_r;
  logic [TAG_W-1:0]         vtag_r;
  logic                     capture;

  assign cnt_inc = (cnt_r == LAST_WORD) ? '0 : cnt_r + WORD_W'(1);

  // State, beat counter and the miss context captured when leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      line_addr_r <= '0;
      way_r       <= '0;
      vtag_r      <= '0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      if (capture) begin
        line_addr_r <= miss_addr[31:OFF_W];
        way_r       <= victim_way;
        vtag_r      <= victim_tag;
      end
    end
  end

  // Next-state logic and bus/array outputs decoded from the current state.
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    capture      = 1'b0;
    rd_word      = '0;
    mem_wr_req   = 1'b0;
    mem_wr_addr  = 32'd0;
    mem_wr_valid = 1'b0;
    mem_wr_data  = 32'd0;
    mem_wr_last  = 1'b0;
    mem_rd_req   = 1'b0;
    mem_rd_addr  = 32'd0;
    line_we      = 1'b0;
    line_word    = '0;
    line_wdata   = 32'd0;
    tag_we       = 1'b0;
    tag_wdata    = '0;
    miss_done    = 1'b0;
    // Array write coordinates come only from the captured context.
    line_way     = way_r;
    line_index   = line_addr_r[INDEX_W-1:0];
    busy         = (state_r != IDLE);

    case (state_r)
      IDLE: begin
        if (miss_req) begin
          capture = 1'b1;
          cnt_nxt = '0;
          // An invalid victim needs no write-back whatever its dirty bit says.
          if (victim_valid && victim_dirty) begin
            state_nxt = WB_REQ;
          end else begin
            state_nxt = RD_REQ;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WB_REQ: begin
        mem_wr_req  = 1'b1;
        mem_wr_addr = {vtag_r, line_addr_r[INDEX_W-1:0], {OFF_W{1'b0}}};
        if (mem_wr_gnt) begin
          state_nxt = WB_DATA;
        end else begin
          state_nxt = WB_REQ;
        end
      end
      WB_DATA: begin
        rd_word      = cnt_r;
        mem_wr_valid = 1'b1;
        mem_wr_data  = rd_data;
        mem_wr_last  = (cnt_r == LAST_WORD);
        if (mem_wr_ready) begin
          cnt_nxt = cnt_inc;
          if (cnt_r == LAST_WORD) begin
            state_nxt = WB_RESP;
          end else begin
            state_nxt = WB_DATA;
          end
        end else begin
          state_nxt = WB_DATA;
        end
      end
      WB_RESP: begin
        if (mem_wr_done) begin
          state_nxt = RD_REQ;
        end else begin
          state_nxt = WB_RESP;
        end
      end
      RD_REQ: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {line_addr_r, {OFF_W{1'b0}}};
        if (mem_rd_gnt) begin
          state_nxt = RD_DATA;
        end else begin
          state_nxt = RD_REQ;
        end
      end
      RD_DATA: begin
        if (mem_rd_valid) begin
          line_we    = 1'b1;
          line_word  = cnt_r;
          line_wdata = mem_rd_data;
          cnt_nxt    = cnt_inc;
          // The bus decides where the burst ends, even on a short burst.
          if (mem_rd_last) begin
            tag_we    = 1'b1;
            tag_wdata = line_addr_r[INDEX_W +: TAG_W];
            state_nxt = DONE;
          end else begin
            state_nxt = RD_DATA;
          end
        end else begin
          state_nxt = RD_DATA;
        end
      end
      DONE: begin
        miss_done = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
module tb_dcache_refill_ctrl;

  logic        clk, rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic [1:0]  victim_way;
  logic        victim_valid, victim_dirty;
  logic [19:0] victim_tag;
  logic [2:0]  rd_word;
  logic [31:0] rd_data;
  logic        mem_wr_req, mem_wr_gnt, mem_wr_valid, mem_wr_last, mem_wr_ready, mem_wr_done;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic        mem_rd_req, mem_rd_gnt, mem_rd_valid, mem_rd_last;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        line_we, tag_we, busy, miss_done;
  logic [1:0]  line_way;
  logic [6:0]  line_index;
  logic [2:0]  line_word;
  logic [31:0] line_wdata;
  logic [19:0] tag_wdata;

  // Victim line contents as seen by the combinational data-array read.
  logic [31:0] line_mem [8];
  assign rd_data = line_mem[rd_word];

  dcache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .rd_word(rd_word), .rd_data(rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_gnt(mem_wr_gnt),
    .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last),
    .mem_wr_ready(mem_wr_ready), .mem_wr_done(mem_wr_done),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
    .line_we(line_we), .line_way(line_way), .line_index(line_index), .line_word(line_word),
    .line_wdata(line_wdata), .tag_we(tag_we), .tag_wdata(tag_wdata),
    .busy(busy), .miss_done(miss_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          active, dirty, wr_gnt_seen, wr_done_seen, rd_gnt_seen, last_seen, post_rst;
  logic [31:0] exp_wr_addr, exp_rd_addr;
  logic [1:0]  cap_way;
  logic [6:0]  cap_index;
  logic [19:0] cap_tag;
  logic [31:0] wr_q [$];
  int          rd_beats, cyc, cap_cyc, done_lat;
  // observations of what the DUT actually did
  logic [31:0] rec_wr_addr, rec_rd_addr, rec_tag;
  logic [31:0] rec_line [8];
  logic [31:0] rec_wdata [8];
  logic [1:0]  rec_way;
  logic [6:0]  rec_index;
  int          tag_cnt, wr_beats, wr_last_beat, wr_req_cnt;

  initial begin
    active = 1'b0; post_rst = 1'b0; cyc = 0; tag_cnt = 0; wr_beats = 0;
    wr_last_beat = 0; wr_req_cnt = 0; done_lat = -1;
  end

  always @(negedge clk) begin : compare
    bit e_wr_req, e_wr_valid, e_resp, e_rd_req, e_rd_phase, e_done;
    cyc++;
    if (rst) begin
      active = 1'b0;
      wr_q.delete();
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("outputs_zero_after_reset",
            {63'd0, |{rd_word, mem_wr_req, mem_wr_addr, mem_wr_valid, mem_wr_data, mem_wr_last,
                      mem_rd_req, mem_rd_addr, line_we, line_way, line_index, line_word,
                      line_wdata, tag_we, tag_wdata, busy, miss_done}}, 64'd0);
        post_rst = 1'b0;
      end
      e_wr_req   = active && dirty && !wr_gnt_seen;
      e_wr_valid = active && dirty && wr_gnt_seen && (wr_q.size() != 0);
      e_resp     = active && dirty && wr_gnt_seen && (wr_q.size() == 0) && !wr_done_seen;
      e_rd_req   = active && !last_seen && (!dirty || wr_done_seen) && !rd_gnt_seen;
      e_rd_phase = active && rd_gnt_seen && !last_seen;
      e_done     = active && last_seen;

      chk("busy", busy, active);
      chk("miss_done", miss_done, e_done);
      chk("mem_wr_req", mem_wr_req, e_wr_req);
      if (e_wr_req) chk("mem_wr_addr", mem_wr_addr, exp_wr_addr);
      chk("mem_wr_valid", mem_wr_valid, e_wr_valid);
      if (e_wr_valid) begin
        chk("mem_wr_data", mem_wr_data, wr_q[0]);
        chk("mem_wr_last", mem_wr_last, wr_q.size() == 1);
        chk("rd_word", rd_word, 8 - wr_q.size());
      end
      chk("mem_rd_req", mem_rd_req, e_rd_req);
      if (e_rd_req) chk("mem_rd_addr", mem_rd_addr, exp_rd_addr);
      chk("line_we", line_we, e_rd_phase && mem_rd_valid);
      chk("tag_we", tag_we, e_rd_phase && mem_rd_valid && mem_rd_last);
      if (e_rd_phase && mem_rd_valid) begin
        chk("line_word", line_word, rd_beats % 8);
        chk("line_wdata", line_wdata, mem_rd_data);
        chk("line_way", line_way, cap_way);
        chk("line_index", line_index, cap_index);
        if (mem_rd_last) begin
          chk("tag_wdata", tag_wdata, cap_tag);
          // a read burst ending early is a bus protocol error
          chk("rd_burst_len", rd_beats + 1, 8);
        end
      end

      // record what the DUT did for the per-test literal checks
      if (tag_we) begin tag_cnt++; rec_tag = {12'd0, tag_wdata}; end
      if (line_we) begin rec_line[line_word] = line_wdata; rec_way = line_way; rec_index = line_index; end
      if (mem_wr_req) begin wr_req_cnt++; rec_wr_addr = mem_wr_addr; end
      if (mem_rd_req) rec_rd_addr = mem_rd_addr;
      if (mem_wr_valid && mem_wr_ready) begin
        rec_wdata[wr_beats % 8] = mem_wr_data;
        if (mem_wr_last) wr_last_beat = wr_beats + 1;
        wr_beats++;
      end

      if (active) begin
        if (e_done) begin active = 1'b0; done_lat = cyc - cap_cyc; end
        if (e_wr_req && mem_wr_gnt) wr_gnt_seen = 1'b1;
        if (e_wr_valid && mem_wr_ready) void'(wr_q.pop_front());
        if (e_resp && mem_wr_done) wr_done_seen = 1'b1;
        if (e_rd_req && mem_rd_gnt) rd_gnt_seen = 1'b1;
        if (e_rd_phase && mem_rd_valid) begin
          rd_beats++;
          if (mem_rd_last) last_seen = 1'b1;
        end
      end else if (miss_req) begin
        active = 1'b1; cap_cyc = cyc; rd_beats = 0;
        wr_gnt_seen = 1'b0; wr_done_seen = 1'b0; rd_gnt_seen = 1'b0; last_seen = 1'b0;
        dirty = victim_valid && victim_dirty;
        wr_q.delete();
        if (dirty) for (int i = 0; i < 8; i++) wr_q.push_back(line_mem[i]);
        exp_wr_addr = {victim_tag, miss_addr[11:5], 5'b00000};
        exp_rd_addr = {miss_addr[31:5], 5'b00000};
        cap_way = victim_way; cap_index = miss_addr[11:5]; cap_tag = miss_addr[31:12];
      end
    end
  end

  // ---------------- stimulus / memory-bus responder ----------------
  // wr_pat: ready pattern over write-data cycles (bit 0 first).
  // rd_pat: valid pattern over read-data cycles (bit 0 first).
  // abort_after: if nonzero, pulse rst once that many read beats have gone.
  task automatic run_miss(input logic [31:0] addr, input logic [1:0] way, input logic vv,
                          input logic vd, input logic [19:0] vtag, input logic [3:0] wr_pat,
                          input logic [1:0] rd_pat, input logic [31:0] rbase, input int abort_after);
    int wr_k = 0, rd_k = 0, rd_sent = 0, wr_hs = 0;
    bit rd_granted = 1'b0, wr_done_given = 1'b0, finished = 1'b0, aborted = 1'b0;
    @(posedge clk); #1;
    miss_req = 1'b1; miss_addr = addr; victim_way = way;
    victim_valid = vv; victim_dirty = vd; victim_tag = vtag;
    for (int c = 0; c < 400 && !finished && !aborted; c++) begin
      @(negedge clk);
      if (mem_wr_valid && mem_wr_ready) wr_hs++;
      if (mem_rd_req && mem_rd_gnt) rd_granted = 1'b1;
      if (mem_rd_valid) rd_sent++;
      if (miss_done) finished = 1'b1;
      @(posedge clk); #1;
      // new miss context while busy must be ignored
      miss_addr = addr ^ 32'hDEAD_BEEF; victim_way = ~way;
      victim_valid = ~vv; victim_dirty = ~vd; victim_tag = ~vtag;
      if (finished) miss_req = 1'b0;
      if (abort_after > 0 && rd_sent == abort_after) begin
        rst = 1'b1; miss_req = 1'b0;
        mem_wr_gnt = 1'b0; mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
        mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_last = 1'b0; mem_rd_data = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        mem_wr_gnt = mem_wr_req;
        mem_rd_gnt = mem_rd_req;
        if (mem_wr_valid) begin mem_wr_ready = wr_pat[wr_k % 4]; wr_k++; end
        else mem_wr_ready = 1'b0;
        mem_wr_done = (wr_hs == 8) && !wr_done_given;
        if (mem_wr_done) wr_done_given = 1'b1;
        if (rd_granted && rd_sent < 8) begin mem_rd_valid = rd_pat[rd_k % 2]; rd_k++; end
        else mem_rd_valid = 1'b0;
        mem_rd_data = mem_rd_valid ? rbase + 32'(rd_sent) : 32'd0;
        mem_rd_last = mem_rd_valid && (rd_sent == 7);
      end
    end
    if (abort_after == 0) chk("miss_completed", finished, 1'b1);
    @(posedge clk); #1;
  endtask

  int tag_before, wrq_before, wb_before;

  initial begin
    rst = 1'b1; miss_req = 1'b0; miss_addr = 32'd0; victim_way = 2'd0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = 20'd0;
    mem_wr_gnt = 1'b0; mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 32'd0; mem_rd_last = 1'b0;
    for (int i = 0; i < 8; i++) line_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_miss_done", miss_done, 1'b0);

    // Clean miss: invalid victim (dirty bit ignored), immediate grants, no stalls.
    wrq_before = wr_req_cnt;
    run_miss(32'h0000_1240, 2'd2, 1'b0, 1'b1, 20'h12345, 4'b1111, 2'b11, 32'h0000_00A0, 0);
    chk("clean_rd_addr", rec_rd_addr, 32'h0000_1240);
    chk("clean_way", rec_way, 2'd2);
    chk("clean_index", rec_index, 7'h12);
    chk("clean_tag", rec_tag, 32'h0000_0001);
    // capture cycle, RD_REQ, 8 beats, DONE: miss_done in the 11th cycle
    chk("clean_latency", done_lat, 10);
    chk("clean_no_writeback", wr_req_cnt - wrq_before, 0);
    for (int i = 0; i < 8; i++) chk("clean_word", rec_line[i], 32'hA0 + i);

    // Dirty miss: write-back first, read only after the write response.
    for (int i = 0; i < 8; i++) line_mem[i] = 32'hD000_0000 + i;
    wb_before = wr_beats;
    run_miss(32'h0000_80A4, 2'd1, 1'b1, 1'b1, 20'h3FFFF, 4'b1111, 2'b11, 32'h0000_00B0, 0);
    chk("dirty_wr_addr", rec_wr_addr, 32'h3FFF_F0A0);  // {tag 3FFFF, index 05, 5'b0}
    chk("dirty_wr_beats", wr_beats - wb_before, 8);
    chk("dirty_last_on_beat8", wr_last_beat - wb_before, 8);
    for (int i = 0; i < 8; i++) chk("dirty_wr_word", rec_wdata[i], 32'hD000_0000 + i);
    chk("dirty_rd_addr", rec_rd_addr, 32'h0000_80A0);
    chk("dirty_tag", rec_tag, 32'h0000_0008);
    chk("dirty_way", rec_way, 2'd1);
    chk("dirty_latency", done_lat, 20);
    for (int i = 0; i < 8; i++) chk("dirty_rd_word", rec_line[i], 32'hB0 + i);

    // Backpressure: ready 1,0,0,1,... and a gap after every read beat.
    for (int i = 0; i < 8; i++) line_mem[i] = 32'hC000_0000 + 32'h11 * i;
    wb_before = wr_beats;
    run_miss(32'h0001_F3E8, 2'd0, 1'b1, 1'b1, 20'h0ABCD, 4'b1001, 2'b01, 32'h0000_00E0, 0);
    chk("bp_wr_addr", rec_wr_addr, 32'h0ABC_D3E0);
    chk("bp_wr_beats", wr_beats - wb_before, 8);
    for (int i = 0; i < 8; i++) chk("bp_wr_word", rec_wdata[i], 32'hC000_0000 + 32'h11 * i);
    chk("bp_rd_addr", rec_rd_addr, 32'h0001_F3E0);
    chk("bp_index", rec_index, 7'h1F);
    chk("bp_tag", rec_tag, 32'h0000_001F);
    // 1+1+16+1+1+15 cycles before DONE
    chk("bp_latency", done_lat, 35);
    for (int i = 0; i < 8; i++) chk("bp_rd_word", rec_line[i], 32'hE0 + i);

    // Reset after four read beats: no tag write, outputs zero next cycle.
    tag_before = tag_cnt;
    run_miss(32'h0000_3460, 2'd3, 1'b0, 1'b0, 20'h00000, 4'b1111, 2'b11, 32'h0000_0050, 4);
    chk("reset_no_tag_write", tag_cnt - tag_before, 0);
    chk("reset_idle_busy", busy, 1'b0);

    // Valid but clean victim: straight to the read.
    wrq_before = wr_req_cnt;
    run_miss(32'h0000_0FE0, 2'd3, 1'b1, 1'b0, 20'h77777, 4'b1111, 2'b11, 32'h0000_0060, 0);
    chk("vclean_no_writeback", wr_req_cnt - wrq_before, 0);
    chk("vclean_latency", done_lat, 10);
    chk("vclean_rd_addr", rec_rd_addr, 32'h0000_0FE0);
    chk("vclean_index", rec_index, 7'h7F);
    chk("vclean_way", rec_way, 2'd3);
    chk("vclean_tag", rec_tag, 32'h0000_0000);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
